// File: rtl/ifu_pkg.sv
// ifu_pkg
//   Shared types and defaults for the instruction-fetch unit.
//   - ifu_state_e   : fetch FSM states
//   - fetch_entry_t : {pc, inst, err} as queued towards decode (default XLEN view)
//   - IFU_RESET_PC  : default fetch PC after reset
package ifu_pkg;

  localparam int unsigned IFU_XLEN     = 32;
  localparam int unsigned IFU_INST_W   = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,   // may issue a request (when a buffer slot is free)
    S_WAIT,  // one request in flight, response will be kept
    S_DROP,  // one request in flight, response will be discarded
    S_HALT   // access fault seen, idle until redirect
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_XLEN-1:0]   pc;
    logic [IFU_INST_W-1:0] inst;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo
//   Synchronous FIFO with flush. DEPTH need not be a power of two; pointers
//   wrap explicitly at DEPTH-1. Flush empties the FIFO and wins over push/pop.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     flush_i    drop all entries
//     push_i     write wdata_i at tail (ignored when full)
//     wdata_i    entry to write
//     pop_i      remove head (ignored when empty)
//     rdata_o    head entry
//     count_o    occupancy 0..DEPTH
//     full_o     count_o == DEPTH
//     empty_o    count_o == 0
module ifu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries data only; no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifu.sv
// ifu
//   Instruction-fetch unit. Holds the fetch PC, issues one-outstanding
//   valid/ready requests to instruction memory and queues {pc, inst, err}
//   for decode. Redirects flush the queue and squash in-flight fetches.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     redirect_valid/redirect_pc   new fetch target (bits [1:0] ignored)
//     imem_req_valid/ready/addr    request channel to instruction memory
//     imem_rsp_valid/data/err      response channel (one per accepted req)
//     out_valid/ready/pc/inst/err  buffer head towards decode
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned      XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IFU_RESET_PC),
  parameter int unsigned      DEPTH    = 2,
  localparam int unsigned     CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_err
);

  localparam int unsigned ENTRY_W = XLEN + 32 + 1;

  ifu_state_e       state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             req_valid_q, req_valid_d;
  logic             req_fire, push, pop;
  logic [CNT_W-1:0] fifo_count, cnt_nxt;
  logic             fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign req_fire       = req_valid_q && imem_req_ready;
  assign pop            = !fifo_empty && out_ready;
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      // A request accepted now, or still unanswered, owes one response
      // that must be thrown away before fetching the new target.
      case (state_q)
        S_REQ:          state_d = req_fire ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d = fetch_pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            push = !fifo_full;
            if (imem_rsp_err) begin
              state_d = S_HALT;
            end else begin
              fetch_pc_d = fetch_pc_q + XLEN'(4);
              state_d    = S_REQ;
            end
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Occupancy after this edge; a request is only raised when the response
  // is guaranteed a free slot.
  always_comb begin
    if (redirect_valid) cnt_nxt = '0;
    else                cnt_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
    req_valid_d = (state_d == S_REQ) && (cnt_nxt < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({req_pc_q, imem_rsp_data, imem_rsp_err}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_rdata[ENTRY_W-1 -: XLEN];
  assign out_inst  = fifo_rdata[32:1];
  assign out_err   = fifo_rdata[0];

endmodule
